riscv_memrsp: RTL

//  Memory-system-side responder for the physical request interface driven by the MMU (preq/padr/psize/plock/pprot/pwe/pd -> pq/pack).

---
 rtl/biu_constants_pkg.sv | 19 +
 rtl/riscv_memrsp_pkg.sv | 22 ++
 rtl/riscv_memrsp_ram.sv | 29 ++
 rtl/riscv_memrsp.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/biu_constants_pkg.sv
// rtl/biu_constants_pkg.sv - bus interface size and protection types shared with the MMU/BIU
package biu_constants_pkg;

  // Access size is log2 of the byte count
  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

  typedef logic [2:0] biu_prot_t;

  localparam biu_prot_t PROT_DATA       = 3'b001;
  localparam biu_prot_t PROT_PRIVILEGED = 3'b010;
  localparam biu_prot_t PROT_CACHEABLE  = 3'b100;

endpackage

// File: rtl/riscv_memrsp_pkg.sv
// rtl/riscv_memrsp_pkg.sv - FSM states and byte-enable helper for riscv_memrsp
package riscv_memrsp_pkg;
  import biu_constants_pkg::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  // Lanes that fall past the end of the word are dropped, never wrapped
  function automatic logic [7:0] size2be(input biu_size_t size, input logic [2:0] offset,
                                         input int xlen);
    logic [15:0] mask;
    mask = (16'd1 << (16'd1 << size)) - 16'd1;
    mask = mask << offset;
    mask = mask & ((16'd1 << (xlen / 8)) - 16'd1);
    return mask[7:0];
  endfunction

endpackage

// File: rtl/riscv_memrsp_ram.sv
// rtl/riscv_memrsp_ram.sv - single-port synchronous SRAM, per-byte write enable, 1-cycle read
module riscv_memrsp_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     en,
  input  logic                     we,
  input  logic [XLEN/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < XLEN / 8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/riscv_memrsp.sv
// rtl/riscv_memrsp.sv - SRAM responder for the MMU physical request port; RISCV_MEMRSP_ERR_EN adds perr_o
module riscv_memrsp
  import biu_constants_pkg::*;
  import riscv_memrsp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PLEN        = XLEN,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            preq_i,
  input  logic [PLEN-1:0] padr_i,
  input  biu_size_t       psize_i,
  input  logic            plock_i,
  input  biu_prot_t       pprot_i,
  input  logic            pwe_i,
  input  logic [XLEN-1:0] pd_i,
  output logic [XLEN-1:0] pq_o,
  output logic            pack_o
`ifdef RISCV_MEMRSP_ERR_EN
  ,
  output logic            perr_o
`endif
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int CNTW  = 4;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PLEN-1:0] adr_q;
  biu_size_t       size_q;
  logic            lock_q, we_q;
  logic [XLEN-1:0] d_q, pq_q, pq_c, ram_rdata;
  logic            resv_valid_q;
  logic [IDXW-1:0] resv_idx_q, idx;
  logic            fail_q;
  logic            err_c, resv_hit, accept, ram_en, ram_we;
  logic [7:0]      be_full;
  logic [BYTES-1:0] be;
  logic            unused_attr;

  assign idx      = adr_q[IDXW+OFFW-1:OFFW];
  assign be_full  = size2be(size_q, 3'(adr_q[OFFW-1:0]), XLEN);
  assign be       = be_full[BYTES-1:0];
  assign resv_hit = resv_valid_q && (resv_idx_q == idx);
  assign unused_attr = ^{pprot_i, adr_q, be_full};

`ifdef RISCV_MEMRSP_ERR_EN
  always_comb begin
    logic [31:0] mis;
    mis   = 32'(adr_q[OFFW-1:0]) & ((32'd1 << size_q) - 32'd1);
    err_c = ((adr_q >> (IDXW + OFFW)) != '0) || (mis != 32'd0) ||
            ((32'd8 << size_q) > 32'(XLEN));
  end
  assign perr_o = (state_q == ACK) && err_c;
`else
  assign err_c = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    pack_o  = 1'b0;
    pq_c    = pq_q;
    unique case (state_q)
      IDLE: begin
        if (preq_i) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = CNTW'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      ACCESS: begin
        ram_en  = 1'b1;
        ram_we  = we_q && !err_c && (!lock_q || resv_hit);
        state_d = ACK;
      end
      ACK: begin
        // the requester still holds preq_i here; it is not a new request
        pack_o  = 1'b1;
        state_d = IDLE;
        if (err_c)     pq_c = '0;
        else if (we_q) pq_c = XLEN'(fail_q);
        else           pq_c = ram_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pq_o = pq_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      adr_q        <= '0;
      size_q       <= BYTE;
      lock_q       <= 1'b0;
      we_q         <= 1'b0;
      d_q          <= '0;
      pq_q         <= '0;
      fail_q       <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pq_q    <= pq_c;
      if (accept) begin
        adr_q  <= padr_i;
        size_q <= psize_i;
        lock_q <= plock_i;
        we_q   <= pwe_i;
        d_q    <= pd_i;
      end
      if (ram_en && !err_c) begin
        fail_q <= lock_q && !resv_hit;
        if (lock_q && !we_q) begin
          resv_valid_q <= 1'b1;
          resv_idx_q   <= idx;
        end else if (we_q && (lock_q || resv_hit)) begin
          resv_valid_q <= 1'b0;
        end
      end
    end
  end

  riscv_memrsp_ram #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i(clk_i),
    .en   (ram_en),
    .we   (ram_we),
    .be   (be),
    .addr (idx),
    .wdata(d_q),
    .rdata(ram_rdata)
  );

endmodule
